// File: rtl/rram_wb_responder.sv
// rram_wb_responder: Wishbone classic-cycle slave that drives timed SET / RESET / READ pulse
// sequences onto one addressed RRAM cell and samples the sense comparator on READ.
//
// Ports:
//   wb_clk_i, wb_rst_ni             clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i      Wishbone control, byte-lane enables
//   wbs_adr_i, wbs_dat_i            byte address, write data
//   wbs_ack_o, wbs_dat_o            registered acknowledge, read data (0 when not acking)
//   sense_i                         asynchronous comparator output
//   rram_row_o, rram_col_o          latched cell select
//   rram_set_o/reset_o/read_o       pulse enables, one-hot or all low
//   irq_o                           done & irq_en, level
module rram_wb_responder #(
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int unsigned ROW_W    = 4,
   parameter int unsigned COL_W    = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic             sense_i,
   output logic [ROW_W-1:0] rram_row_o,
   output logic [COL_W-1:0] rram_col_o,
   output logic             rram_set_o,
   output logic             rram_reset_o,
   output logic             rram_read_o,
   output logic             irq_o
);

   localparam logic [CNT_W-1:0] PulseRst  = CNT_W'(10);
   localparam logic [CNT_W-1:0] SettleRst = CNT_W'(2);
   localparam logic [CNT_W-1:0] One       = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lat_pulse_q, lat_pulse_d, lat_settle_q, lat_settle_d;
   logic [1:0]       lat_op_q, lat_op_d;
   logic [1:0]       ctrl_op_q, ctrl_op_d;
   logic             irq_en_q, irq_en_d;
   logic [ROW_W-1:0] addr_row_q, addr_row_d, row_q, row_d;
   logic [COL_W-1:0] addr_col_q, addr_col_d, col_q, col_d;
   logic [CNT_W-1:0] pulse_q, pulse_d, settle_q, settle_d;
   logic             done_q, done_d, err_q, err_d, result_q, result_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic             sense_meta_q, sense_sync_q;

   logic             busy, req, wr, hit;
   logic [5:0]       off;
   logic [31:0]      rdata, wmask, wnew, wclr;
   logic [CNT_W-1:0] eff_p, eff_s;
   logic             unused_bits;

   assign hit   = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign off   = wbs_adr_i[7:2];
   assign req   = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
   assign wr    = req & wbs_we_i;
   assign busy  = (state_q != StIdle);
   assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   // Merge of current contents with the enabled byte lanes; start bit reads 0 so it only
   // appears here when sel[3] carries it.
   assign wnew  = (rdata & ~wmask) | (wbs_dat_i & wmask);
   assign wclr  = wbs_dat_i & wmask;
   assign eff_p = (pulse_q == '0) ? One : pulse_q;
   assign eff_s = (settle_q == '0) ? One : settle_q;
   assign unused_bits = ^{wbs_adr_i[1:0], wnew, wclr};

   always_comb begin
      rdata = '0;
      case (off)
         6'h00: begin
            rdata[1:0] = ctrl_op_q;
            rdata[8]   = irq_en_q;
         end
         6'h01: begin
            rdata[ROW_W-1:0]     = addr_row_q;
            rdata[16+COL_W-1:16] = addr_col_q;
         end
         6'h02:   rdata[CNT_W-1:0] = pulse_q;
         6'h03:   rdata[CNT_W-1:0] = settle_q;
         6'h04:   rdata[3:0] = {result_q, err_q, done_q, busy};
         default: rdata = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lat_pulse_d  = lat_pulse_q;
      lat_settle_d = lat_settle_q;
      lat_op_d     = lat_op_q;
      ctrl_op_d    = ctrl_op_q;
      irq_en_d     = irq_en_q;
      addr_row_d   = addr_row_q;
      addr_col_d   = addr_col_q;
      row_d        = row_q;
      col_d        = col_q;
      pulse_d      = pulse_q;
      settle_d     = settle_q;
      done_d       = done_q;
      err_d        = err_q;
      result_d     = result_q;
      ack_d        = req;
      dat_d        = (req && !wbs_we_i) ? rdata : '0;

      if (wr) begin
         case (off)
            6'h00: begin
               ctrl_op_d = wnew[1:0];
               irq_en_d  = wnew[8];
               if (wnew[31]) begin
                  if (state_q == StIdle && wnew[1:0] != 2'b00) begin
                     state_d      = StSetup;
                     cnt_d        = eff_s - One;
                     lat_op_d     = wnew[1:0];
                     lat_pulse_d  = eff_p;
                     lat_settle_d = eff_s;
                     row_d        = addr_row_q;
                     col_d        = addr_col_q;
                     done_d       = 1'b0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            6'h01: begin
               addr_row_d = wnew[ROW_W-1:0];
               addr_col_d = wnew[16+COL_W-1:16];
            end
            6'h02: pulse_d  = wnew[CNT_W-1:0];
            6'h03: settle_d = wnew[CNT_W-1:0];
            6'h04: begin
               if (wclr[1]) done_d = 1'b0;
               if (wclr[2]) err_d  = 1'b0;
            end
            default: ;
         endcase
      end

      // Sequencer runs after the bus decode so a completing HOLD wins over a W1C of done.
      case (state_q)
         StSetup: begin
            if (cnt_q == '0) begin
               state_d = StPulse;
               cnt_d   = lat_pulse_q - One;
            end else begin
               cnt_d = cnt_q - One;
            end
         end
         StPulse: begin
            if (cnt_q == '0) begin
               state_d = StHold;
               cnt_d   = lat_settle_q - One;
               if (lat_op_q == 2'b11) result_d = sense_sync_q;
            end else begin
               cnt_d = cnt_q - One;
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - One;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      rram_set_o   = (state_q == StPulse) && (lat_op_q == 2'b01);
      rram_reset_o = (state_q == StPulse) && (lat_op_q == 2'b10);
      rram_read_o  = (state_q == StPulse) && (lat_op_q == 2'b11);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         lat_pulse_q  <= '0;
         lat_settle_q <= '0;
         lat_op_q     <= '0;
         ctrl_op_q    <= '0;
         irq_en_q     <= 1'b0;
         addr_row_q   <= '0;
         addr_col_q   <= '0;
         row_q        <= '0;
         col_q        <= '0;
         pulse_q      <= PulseRst;
         settle_q     <= SettleRst;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         result_q     <= 1'b0;
         ack_q        <= 1'b0;
         dat_q        <= '0;
         sense_meta_q <= 1'b0;
         sense_sync_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lat_pulse_q  <= lat_pulse_d;
         lat_settle_q <= lat_settle_d;
         lat_op_q     <= lat_op_d;
         ctrl_op_q    <= ctrl_op_d;
         irq_en_q     <= irq_en_d;
         addr_row_q   <= addr_row_d;
         addr_col_q   <= addr_col_d;
         row_q        <= row_d;
         col_q        <= col_d;
         pulse_q      <= pulse_d;
         settle_q     <= settle_d;
         done_q       <= done_d;
         err_q        <= err_d;
         result_q     <= result_d;
         ack_q        <= ack_d;
         dat_q        <= dat_d;
         sense_meta_q <= sense_i;
         sense_sync_q <= sense_meta_q;
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign rram_row_o = row_q;
   assign rram_col_o = col_q;
   assign irq_o      = done_q & irq_en_q;

endmodule

// File: tb/tb_rram_wb_responder.sv
// Directed bench for rram_wb_responder: register access, SET/READ/RESET sequencing,
// error handling, minimum timing, mid-sequence reset and address decode.
module tb_rram_wb_responder;

   localparam logic [31:0] B = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0, wdat = '0;
   logic        ack;
   logic [31:0] rdat_o;
   logic        sense = 1'b0;
   logic [3:0]  row, col;
   logic        p_set, p_reset, p_read, irq;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rram_wb_responder dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .wbs_cyc_i    (cyc),
      .wbs_stb_i    (stb),
      .wbs_we_i     (we),
      .wbs_sel_i    (sel),
      .wbs_adr_i    (adr),
      .wbs_dat_i    (wdat),
      .wbs_ack_o    (ack),
      .wbs_dat_o    (rdat_o),
      .sense_i      (sense),
      .rram_row_o   (row),
      .rram_col_o   (col),
      .rram_set_o   (p_set),
      .rram_reset_o (p_reset),
      .rram_read_o  (p_read),
      .irq_o        (irq)
   );

   // One bus transaction, bounded to 4 cycles; lat = cycles to ack, 0 if never acked.
   // Waits out a still-high ack first so each request starts on an idle bus.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output int lat);
      bit got;
      if (ack) begin @(posedge clk); #1; end
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      lat = 0; rd = '0; got = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!got) begin
            @(posedge clk); #1;
            if (ack) begin got = 1'b1; lat = i; rd = rdat_o; end
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd; int lat;
      xfer(1'b1, a, d, 4'hF, rd, lat);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      int lat;
      xfer(1'b0, a, 32'h0, 4'hF, d, lat);
   endtask

   task automatic test_reset;
      logic [31:0] d, exp_d; int lat;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({ack, rdat_o, row, col, p_set, p_reset, p_read, irq} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got ack=%b dat=%h row=%h col=%h p=%b%b%b irq=%b want all 0",
                  ack, rdat_o, row, col, p_set, p_reset, p_read, irq);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         case (i)
            2:       exp_d = 32'h0000_000A;
            3:       exp_d = 32'h0000_0002;
            default: exp_d = 32'h0;
         endcase
         xfer(1'b0, B + 32'(i * 4), 32'h0, 4'hF, d, lat);
         vectors++;
         if (d !== exp_d || lat != 1) begin
            miscompares++;
            $display("FAIL reset_reg[%0d] got %h lat %0d want %h lat 1", i, d, lat, exp_d);
         end
      end
   endtask

   task automatic test_byte_lanes;
      logic [31:0] d; int lat;
      xfer(1'b1, B + 32'h04, 32'hFFFF_FFFF, 4'b0100, d, lat);
      rd(B + 32'h04, d);
      vectors++;
      if (d !== 32'h000F_0000) begin
         miscompares++;
         $display("FAIL lane_addr got %h want 000f0000", d);
      end
      // start bit without sel[3] must neither start nor flag an error
      xfer(1'b1, B + 32'h00, 32'h8000_0101, 4'b0011, d, lat);
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h0 || p_set !== 1'b0) begin
         miscompares++;
         $display("FAIL lane_nostart status %h set %b want 0 0", d, p_set);
      end
      rd(B + 32'h00, d);
      vectors++;
      if (d !== 32'h0000_0101) begin
         miscompares++;
         $display("FAIL lane_ctrl got %h want 00000101", d);
      end
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B + 32'h08; sel = 4'hF;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         vectors++;
         if ({ack, rdat_o} !== ((i % 2 == 1) ? {1'b1, 32'h0000_000A} : 33'h0)) begin
            miscompares++;
            $display("FAIL b2b cycle %0d got ack=%b dat=%h", i, ack, rdat_o);
         end
      end
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_set;
      logic [31:0] d; int lat; logic [3:0] exp_v;
      wr(B + 32'h04, 32'h0003_0005);
      wr(B + 32'h0C, 32'd3);
      wr(B + 32'h08, 32'd4);
      xfer(1'b1, B + 32'h00, 32'h8000_0101, 4'hF, d, lat);
      vectors++;
      if (lat != 1 || row !== 4'h5 || col !== 4'h3 || {p_set, p_reset, p_read} !== 3'b000) begin
         miscompares++;
         $display("FAIL set_start lat %0d row %h col %h p %b%b%b want 1 5 3 000",
                  lat, row, col, p_set, p_reset, p_read);
      end
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         exp_v = {((k >= 3 && k <= 6) ? 3'b100 : 3'b000), (k >= 10)};
         vectors++;
         if ({p_set, p_reset, p_read, irq} !== exp_v) begin
            miscompares++;
            $display("FAIL set_seq k=%0d got %b want %b", k, {p_set, p_reset, p_read, irq}, exp_v);
         end
      end
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h2) begin
         miscompares++;
         $display("FAIL set_status got %h want 2", d);
      end
      wr(B + 32'h10, 32'h2);
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         miscompares++;
         $display("FAIL done_w1c status %h irq %b want 0 0", d, irq);
      end
   endtask

   task automatic test_read;
      logic [31:0] d; logic [2:0] exp_p;
      sense = 1'b1;
      wr(B + 32'h00, 32'h8000_0103);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         exp_p = (k >= 3 && k <= 6) ? 3'b001 : 3'b000;
         vectors++;
         if ({p_set, p_reset, p_read} !== exp_p) begin
            miscompares++;
            $display("FAIL read_seq k=%0d got %b want %b", k, {p_set, p_reset, p_read}, exp_p);
         end
      end
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'hA) begin
         miscompares++;
         $display("FAIL read_sense1 status %h want a", d);
      end
      sense = 1'b0;
      wr(B + 32'h00, 32'h8000_0103);
      repeat (12) @(posedge clk);
      #1;
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h2 || row !== 4'h5 || col !== 4'h3) begin
         miscompares++;
         $display("FAIL read_sense0 status %h row %h col %h want 2 5 3", d, row, col);
      end
   endtask

   task automatic test_error;
      logic [31:0] d;
      wr(B + 32'h00, 32'h8000_0101);   // k=0
      wr(B + 32'h00, 32'h8000_0102);   // k=2, rejected: busy
      rd(B + 32'h10, d);               // k=4
      vectors++;
      if (d !== 32'h5 || p_set !== 1'b1) begin
         miscompares++;
         $display("FAIL err_busy status %h set %b want 5 1", d, p_set);
      end
      for (int k = 5; k <= 12; k++) begin
         @(posedge clk); #1;
         vectors++;
         if ({p_set, p_reset, p_read} !== ((k <= 6) ? 3'b100 : 3'b000)) begin
            miscompares++;
            $display("FAIL err_seq k=%0d got %b", k, {p_set, p_reset, p_read});
         end
      end
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h6) begin
         miscompares++;
         $display("FAIL err_after status %h want 6", d);
      end
      wr(B + 32'h10, 32'h4);
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h2) begin
         miscompares++;
         $display("FAIL err_w1c status %h want 2", d);
      end
      wr(B + 32'h00, 32'h8000_0100);
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h6 || {p_set, p_reset, p_read} !== 3'b000) begin
         miscompares++;
         $display("FAIL err_op0 status %h p %b%b%b want 6 000", d, p_set, p_reset, p_read);
      end
      wr(B + 32'h10, 32'h6);
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL err_clear status %h want 0", d);
      end
   endtask

   task automatic test_min;
      logic [3:0] exp_v;
      wr(B + 32'h08, 32'h0);
      wr(B + 32'h0C, 32'h0);
      wr(B + 32'h00, 32'h8000_0102);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         exp_v = {((k == 1) ? 3'b010 : 3'b000), (k >= 3)};
         vectors++;
         if ({p_set, p_reset, p_read, irq} !== exp_v) begin
            miscompares++;
            $display("FAIL min_seq k=%0d got %b want %b", k, {p_set, p_reset, p_read, irq}, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wr(B + 32'h08, 32'd5);
      wr(B + 32'h0C, 32'd2);
      wr(B + 32'h00, 32'h8000_0101);
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (p_set !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_pulse set %b want 1", p_set);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({p_set, p_reset, p_read, irq, ack, row, col} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset p %b%b%b irq %b ack %b row %h col %h want 0",
                  p_set, p_reset, p_read, irq, ack, row, col);
      end
      rst_n = 1'b1;
      rd(B + 32'h08, d);
      vectors++;
      if (d !== 32'hA) begin
         miscompares++;
         $display("FAIL mid_pulse_reg got %h want a", d);
      end
      rd(B + 32'h0C, d);
      vectors++;
      if (d !== 32'h2) begin
         miscompares++;
         $display("FAIL mid_settle_reg got %h want 2", d);
      end
      rd(B + 32'h10, d);
      vectors++;
      if (d !== 32'h0 || p_set !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_status got %h set %b want 0 0", d, p_set);
      end
      rd(B + 32'h00, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_ctrl got %h want 0", d);
      end
   endtask

   task automatic test_unmapped;
      logic [31:0] d; int lat;
      xfer(1'b1, B + 32'h1C, 32'hFFFF_FFFF, 4'hF, d, lat);
      vectors++;
      if (lat != 1) begin
         miscompares++;
         $display("FAIL unmapped_wr lat %0d want 1", lat);
      end
      xfer(1'b0, B + 32'h1C, 32'h0, 4'hF, d, lat);
      vectors++;
      if (lat != 1 || d !== 32'h0) begin
         miscompares++;
         $display("FAIL unmapped_rd lat %0d data %h want 1 0", lat, d);
      end
      xfer(1'b1, 32'h3000_0100, 32'hFFFF_FFFF, 4'hF, d, lat);
      vectors++;
      if (lat != 0) begin
         miscompares++;
         $display("FAIL nohit_wr acked after %0d want never", lat);
      end
      xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, d, lat);
      vectors++;
      if (lat != 0) begin
         miscompares++;
         $display("FAIL nohit_rd acked after %0d want never", lat);
      end
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_back_to_back();
      test_set();
      test_read();
      test_error();
      test_min();
      test_reset_mid();
      test_unmapped();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
